mpu6050_uart_formatter: RTL and testbench

//  Sits between the I2C read path (MPU6050 accel burst 0x3B..0x40) and the UART TX.

---
 rtl/mpu6050_uart_formatter_pkg.sv | 24 ++
 rtl/mpu6050_uart_formatter_hex_nibble_ascii.sv | 22 ++
 rtl/mpu6050_uart_formatter.sv | 151 +++++++++++++++
 tb/tb_mpu6050_uart_formatter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu6050_uart_formatter_pkg.sv
// Shared constants for the MPU6050 sample-to-UART line formatter.
//   - ASCII characters used in the fixed part of the line
//   - line lengths with and without the CR/LF terminator
//   - FSM state encoding (2-bit)
package mpu6050_uart_formatter_pkg;

  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_Y     = 8'h59;
  localparam logic [7:0] CH_Z     = 8'h5A;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam int FRAME_LEN_CRLF   = 22;
  localparam int FRAME_LEN_NOCRLF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/mpu6050_uart_formatter_hex_nibble_ascii.sv
// Combinational 4-bit value to ASCII hex digit.
//   nibble : value 0..15
//   ascii  : '0'..'9', then 'A'..'F' (HEX_UPPER=1) or 'a'..'f' (HEX_UPPER=0)
module mpu6050_uart_formatter_hex_nibble_ascii #(
  parameter int HEX_UPPER = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0x37 + 10 = 'A', 0x57 + 10 = 'a'
  localparam logic [7:0] ALPHA_BASE = (HEX_UPPER != 0) ? 8'h37 : 8'h57;

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'd0, nibble};
    end else begin
      ascii = ALPHA_BASE + {4'd0, nibble};
    end
  end

endmodule

// File: rtl/mpu6050_uart_formatter.sv
// Captures one 6-byte MPU6050 accel sample (XH XL YH YL ZH ZL) and streams it
// to a UART as the ASCII line "X:hhhh Y:hhhh Z:hhhh" (+ "\r\n" if SEND_CRLF).
// Samples completing while a line is in flight are dropped and counted.
// Ports:
//   dev_clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_sof/in_data sample byte strobe, first-byte flag, byte
//   tx_valid/tx_ready/tx_data  character stream to the UART
//   busy                    a line is being emitted (state != IDLE)
//   frame_done              high on the cycle the last character is accepted
//   burst_err               1-cycle pulse: in_sof seen with a partial sample held
//   overrun_cnt             saturating count of dropped complete samples
//   dbg_state               current FSM state, for observation only
// Handshake: a character transfers on a cycle where tx_valid & tx_ready.
// Once tx_valid is high, tx_valid and tx_data hold until that transfer;
// only reset can withdraw tx_valid.
module mpu6050_uart_formatter
  import mpu6050_uart_formatter_pkg::*;
#(
  parameter int HEX_UPPER = 1,
  parameter int SEND_CRLF = 1,
  parameter int OVR_W     = 8
) (
  input  logic             dev_clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             frame_done,
  output logic             burst_err,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic [1:0]       dbg_state
);

  localparam int         FRAME_LEN = (SEND_CRLF != 0) ? FRAME_LEN_CRLF : FRAME_LEN_NOCRLF;
  localparam logic [4:0] LAST_CIDX = 5'(FRAME_LEN - 1);

  logic [2:0]       bidx;
  logic [5:0][7:0]  cap;
  logic [47:0]      frame;
  state_t           state;
  logic [4:0]       cidx;

  logic sof_byte, data_byte, sample_done, accept;

  assign sof_byte    = in_valid & in_sof;
  assign data_byte   = in_valid & ~in_sof & (bidx < 3'd6);
  assign sample_done = data_byte & (bidx == 3'd5);
  assign accept      = (state == ST_SEND) & tx_ready;

  // Capture path: bidx parks at 6 after a full sample until the next sof.
  always_ff @(posedge dev_clk or negedge rst_n) begin
    if (!rst_n) begin
      bidx      <= 3'd0;
      cap       <= '0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= sof_byte & (bidx != 3'd0) & (bidx < 3'd6);
      if (sof_byte) begin
        cap[0] <= in_data;
        bidx   <= 3'd1;
      end else if (data_byte) begin
        cap[bidx] <= in_data;
        bidx      <= bidx + 3'd1;
      end
    end
  end

  // Any sample completing outside IDLE is dropped, including on the cycle
  // the last character is accepted.
  always_ff @(posedge dev_clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (sample_done && (state != ST_IDLE) && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

  // LOAD copies the capture buffer one edge after completion; a new sof byte
  // landing on that same edge is not yet visible, so the frame stays intact.
  always_ff @(posedge dev_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      frame <= '0;
      cidx  <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: if (sample_done) state <= ST_LOAD;
        ST_LOAD: begin
          frame <= {cap[0], cap[1], cap[2], cap[3], cap[4], cap[5]};
          cidx  <= 5'd0;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (accept) begin
            if (cidx == LAST_CIDX) begin
              cidx  <= 5'd0;
              state <= ST_IDLE;
            end else begin
              cidx <= cidx + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Nibble k (0 = XH[7:4] .. 11 = ZL[3:0]) for the hex positions of the line.
  logic [3:0] nib_k, nib;
  logic [7:0] hex_ch, ch;

  always_comb begin
    nib_k = 4'd0;
    if (cidx >= 5'd16)     nib_k = 4'(cidx - 5'd8);
    else if (cidx >= 5'd9) nib_k = 4'(cidx - 5'd5);
    else if (cidx >= 5'd2) nib_k = 4'(cidx - 5'd2);
  end

  assign nib = 4'(frame >> {4'(4'd11 - nib_k), 2'b00});

  mpu6050_uart_formatter_hex_nibble_ascii #(
    .HEX_UPPER (HEX_UPPER)
  ) u_hex (
    .nibble (nib),
    .ascii  (hex_ch)
  );

  always_comb begin
    case (cidx)
      5'd0:                ch = CH_X;
      5'd7:                ch = CH_Y;
      5'd14:               ch = CH_Z;
      5'd1, 5'd8, 5'd15:   ch = CH_COLON;
      5'd6, 5'd13:         ch = CH_SP;
      5'd20:               ch = CH_CR;
      5'd21:               ch = CH_LF;
      default:             ch = hex_ch;
    endcase
  end

  assign tx_valid   = (state == ST_SEND);
  assign tx_data    = (state == ST_SEND) ? ch : 8'h00;
  assign busy       = (state != ST_IDLE);
  assign frame_done = accept & (cidx == LAST_CIDX);
  assign dbg_state  = state;

endmodule

// File: tb/tb_mpu6050_uart_formatter.sv
// Bench for mpu6050_uart_formatter: two instances share the input stream and
// tx_ready (u_dut0: upper hex, CR/LF, 8-bit counter; u_dut1: lower hex,
// no terminator, 4-bit counter) and are checked against a line-level model.
module tb_mpu6050_uart_formatter;

  logic       dev_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       tx_ready = 1'b0;

  logic       tx_valid0, busy0, frame_done0, burst_err0;
  logic [7:0] tx_data0, ovr0;
  logic [1:0] st0;
  logic       tx_valid1, busy1, frame_done1, burst_err1;
  logic [7:0] tx_data1;
  logic [3:0] ovr1;
  logic [1:0] st1;

  // ---------------- clock / reset ----------------
  always #5 dev_clk = ~dev_clk;

  mpu6050_uart_formatter #(.HEX_UPPER(1), .SEND_CRLF(1), .OVR_W(8)) u_dut0 (
    .dev_clk(dev_clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .tx_valid(tx_valid0), .tx_ready(tx_ready), .tx_data(tx_data0),
    .busy(busy0), .frame_done(frame_done0), .burst_err(burst_err0),
    .overrun_cnt(ovr0), .dbg_state(st0)
  );

  mpu6050_uart_formatter #(.HEX_UPPER(0), .SEND_CRLF(0), .OVR_W(4)) u_dut1 (
    .dev_clk(dev_clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .tx_valid(tx_valid1), .tx_ready(tx_ready), .tx_data(tx_data1),
    .busy(busy1), .frame_done(frame_done1), .burst_err(burst_err1),
    .overrun_cnt(ovr1), .dbg_state(st1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: bytes captured, held sample, line phase (0 idle, 1 load,
  // 2 send), characters left, overrun count, expected character queue.
  int len_c[2]   = '{22, 20};
  int upper_c[2] = '{1, 0};
  int ovr_max[2] = '{255, 15};

  int         m_cnt[2], m_phase[2], m_rem[2], m_ovr[2];
  int         m_berr_exp[2], berr_seen[2];
  logic [7:0] m_cap[2][6];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         rdy_mode = 0;   // 0 always ready, 1 random, 2 never

  function automatic logic [7:0] hex_ascii(input logic [3:0] n, input int up);
    if (n < 10) return 8'(48 + int'(n));
    return up != 0 ? 8'(65 + int'(n) - 10) : 8'(97 + int'(n) - 10);
  endfunction

  task automatic push_exp(input int d, input logic [7:0] c);
    if (d == 0) exp_q0.push_back(c);
    else        exp_q1.push_back(c);
  endtask

  // Builds the whole expected line from the held sample.
  task automatic load_line(input int d);
    logic [15:0] w;
    for (int a = 0; a < 3; a++) begin
      if (a > 0) push_exp(d, 8'd32);
      push_exp(d, 8'(88 + a));
      push_exp(d, 8'd58);
      w = {m_cap[d][2*a], m_cap[d][2*a+1]};
      for (int k = 3; k >= 0; k--) push_exp(d, hex_ascii(4'(w >> (4*k)), upper_c[d]));
    end
    if (len_c[d] == 22) begin
      push_exp(d, 8'd13);
      push_exp(d, 8'd10);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_phase[d] = 0; m_rem[d] = 0; m_ovr[d] = 0;
      for (int i = 0; i < 6; i++) m_cap[d][i] = 8'h00;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_outputs();
    logic       v, b, fd, be;
    logic [7:0] dat, front;
    int         qs;
    for (int d = 0; d < 2; d++) begin
      v   = d == 0 ? tx_valid0 : tx_valid1;
      b   = d == 0 ? busy0 : busy1;
      fd  = d == 0 ? frame_done0 : frame_done1;
      be  = d == 0 ? burst_err0 : burst_err1;
      dat = d == 0 ? tx_data0 : tx_data1;
      qs  = d == 0 ? exp_q0.size() : exp_q1.size();
      check($sformatf("d%0d tx_valid", d), 32'(v), 32'(m_phase[d] == 2));
      check($sformatf("d%0d busy", d), 32'(b), 32'(m_phase[d] != 0));
      check($sformatf("d%0d frame_done", d), 32'(fd),
            32'(m_phase[d] == 2 && tx_ready && m_rem[d] == 1));
      if (m_phase[d] == 2) begin
        if (qs == 0) begin
          check($sformatf("d%0d exp_q underflow", d), 32'(qs), 32'd1);
        end else begin
          front = d == 0 ? exp_q0[0] : exp_q1[0];
          check($sformatf("d%0d tx_data", d), 32'(dat), 32'(front));
        end
      end
      if (be) berr_seen[d]++;
    end
  endtask

  // Advances the model across one rising edge with the given inputs.
  task automatic model_step(input logic v, input logic s, input logic [7:0] data, input logic r);
    logic complete;
    int   old_phase;
    for (int d = 0; d < 2; d++) begin
      complete  = v && !s && m_cnt[d] == 5;
      old_phase = m_phase[d];
      if (old_phase == 1) begin
        load_line(d);
        m_phase[d] = 2;
        m_rem[d]   = len_c[d];
      end else if (old_phase == 2 && r) begin
        if (d == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
        if (d == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
        m_rem[d]--;
        if (m_rem[d] == 0) m_phase[d] = 0;
      end else if (old_phase == 0 && complete) begin
        m_phase[d] = 1;
      end
      if (complete && old_phase != 0 && m_ovr[d] < ovr_max[d]) m_ovr[d]++;
      if (v && s) begin
        if (m_cnt[d] > 0 && m_cnt[d] < 6) m_berr_exp[d]++;
        m_cap[d][0] = data;
        m_cnt[d]    = 1;
      end else if (v && m_cnt[d] < 6) begin
        m_cap[d][m_cnt[d]] = data;
        m_cnt[d]++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic rdy();
    if (rdy_mode == 0) return 1'b1;
    if (rdy_mode == 2) return 1'b0;
    return $urandom_range(0, 9) < 7;
  endfunction

  // Called just after a falling edge; drives one cycle of inputs.
  task automatic tick(input logic v, input logic s, input logic [7:0] data, input logic r);
    in_valid = v; in_sof = s; in_data = data; tx_ready = r;
    #1;
    check_outputs();
    model_step(v, s, data, r);
    @(negedge dev_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, rdy());
  endtask

  task automatic burst(input logic [47:0] w, input int gap_max);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, i == 0, w[47-8*i -: 8], rdy());
      if (i < 5 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic drain();
    int save;
    save = rdy_mode;
    rdy_mode = 0;
    for (int i = 0; i < 120 && (m_phase[0] != 0 || m_phase[1] != 0); i++) idle(1);
    idle(2);
    rdy_mode = save;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst tx_valid0", 32'(tx_valid0), 32'd0);
    check("rst tx_valid1", 32'(tx_valid1), 32'd0);
    check("rst busy0", 32'(busy0), 32'd0);
    check("rst busy1", 32'(busy1), 32'd0);
    check("rst tx_data0", 32'(tx_data0), 32'd0);
    check("rst ovr0", 32'(ovr0), 32'd0);
    check("rst ovr1", 32'(ovr1), 32'd0);
    check("rst burst_err0", 32'(burst_err0), 32'd0);
    check("rst state0", 32'(st0), 32'd0);
    model_reset();
    @(negedge dev_clk);
    @(negedge dev_clk);
    in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stall, stalled, kind, nb;
    berr_seen  = '{0, 0};
    m_berr_exp = '{0, 0};
    @(negedge dev_clk);
    do_reset();

    // basic line, always ready
    rdy_mode = 0;
    burst(48'hDEADBEEFC0DE, 0);
    drain();

    // stall 5 cycles at character index 9
    burst(48'hDEADBEEFC0DE, 0);
    stall = 0; stalled = 0;
    for (int i = 0; i < 120 && (m_phase[0] != 0 || m_phase[1] != 0); i++) begin
      if (!stalled && m_phase[0] == 2 && m_rem[0] == 13) begin
        stall = 5; stalled = 1;
      end
      tick(1'b0, 1'b0, 8'h00, stall == 0);
      if (stall > 0) stall--;
    end
    drain();

    // overrun during a line, then saturation under a stalled UART
    burst(48'hDEADBEEFC0DE, 0);
    idle(3);
    burst(48'h112233445566, 0);
    drain();
    check("t3 ovr0", 32'(ovr0), 32'd1);
    check("t3 ovr1", 32'(ovr1), 32'd1);
    burst(48'hA5A55A5A0F0F, 0);
    idle(2);
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) burst({$urandom, 16'($urandom)}, 0);
    check("sat ovr0", 32'(ovr0), 32'hFF);
    check("sat ovr1", 32'(ovr1), 32'hF);
    rdy_mode = 0;
    drain();

    // partial burst then a fresh one
    nb = berr_seen[0];
    tick(1'b1, 1'b1, 8'h77, 1'b1);
    tick(1'b1, 1'b0, 8'h88, 1'b1);
    tick(1'b1, 1'b0, 8'h99, 1'b1);
    burst(48'h0123456789AB, 0);
    drain();
    check("t4 burst_err0", 32'(berr_seen[0] - nb), 32'd1);

    // randomized traffic with back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        burst({$urandom, 16'($urandom)}, 2);
      end else if (kind == 7) begin
        nb = $urandom_range(1, 5);
        for (int i = 0; i < nb; i++) tick(1'b1, i == 0, 8'($urandom), rdy());
      end else begin
        tick(1'b1, 1'b0, 8'($urandom), rdy());
      end
      idle($urandom_range(0, 30));
    end
    drain();
    check("rand ovr0", 32'(ovr0), 32'(m_ovr[0]));
    check("rand ovr1", 32'(ovr1), 32'(m_ovr[1]));

    // reset in the middle of a line, then a clean line
    rdy_mode = 0;
    burst(48'hDEADBEEFC0DE, 0);
    for (int i = 0; i < 40 && !(m_phase[0] == 2 && m_rem[0] == 12); i++) idle(1);
    check("t5 reached cidx10", 32'(m_rem[0]), 32'd12);
    do_reset();
    burst(48'hDEADBEEFC0DE, 0);
    drain();

    check("berr0 total", 32'(berr_seen[0]), 32'(m_berr_exp[0]));
    check("berr1 total", 32'(berr_seen[1]), 32'(m_berr_exp[1]));
    check("exp_q0 empty", 32'(exp_q0.size()), 32'd0);
    check("exp_q1 empty", 32'(exp_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
